// File: rtl/fp_wb_arbiter_pkg.sv
// Shared types and helpers for the FP writeback arbiter.
// Optional round-robin selection is enabled with FP_WB_ARB_RR_EN.
package fp_wb_arbiter_pkg;

  localparam int NUM_FP_WB_SRC  = 4;
  localparam int NUM_FP_WB_PORT = 2;
  localparam int FP_XLEN        = 64;
  localparam int FP_ROB_WIDTH   = 6;
  localparam int FP_PREG_WIDTH  = 7;
  localparam int FP_FLAG_WIDTH  = 5;
  localparam int FP_WB_SRC_IW   = $clog2(NUM_FP_WB_SRC);

  typedef struct packed {
    logic                     en;
    logic [FP_ROB_WIDTH-1:0]  robIdx;
    logic [FP_XLEN-1:0]       res;
    logic [FP_PREG_WIDTH-1:0] rd;
    logic                     we;
    logic [FP_FLAG_WIDTH-1:0] exccode;
  } fp_wb_entry_t;

  // 1 when a is strictly younger than b; MSB is the ROB wrap bit.
  function automatic logic loop_compare(input logic [FP_ROB_WIDTH-1:0] a,
                                        input logic [FP_ROB_WIDTH-1:0] b);
    logic same_wrap;
    same_wrap = (a[FP_ROB_WIDTH-1] == b[FP_ROB_WIDTH-1]);
    if (same_wrap) begin
      return (a[FP_ROB_WIDTH-2:0] > b[FP_ROB_WIDTH-2:0]);
    end else begin
      return (a[FP_ROB_WIDTH-2:0] < b[FP_ROB_WIDTH-2:0]);
    end
  endfunction

  function automatic logic [FP_WB_SRC_IW-1:0] onehot_to_idx(input logic [NUM_FP_WB_SRC-1:0] v);
    logic [FP_WB_SRC_IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_FP_WB_SRC; i++) begin
      if (v[i]) begin
        idx = idx | FP_WB_SRC_IW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/fp_wb_arbiter_if.sv
// Writeback bus between FP execute slots and the arbiter, plus the arbiter's
// regfile/ROB/wakeup outputs. slave = arbiter view, master = producer view.
interface fp_wb_arbiter_if;
  import fp_wb_arbiter_pkg::*;

  logic [NUM_FP_WB_SRC-1:0]                src_en;
  logic [NUM_FP_WB_SRC*FP_ROB_WIDTH-1:0]   src_robIdx;
  logic [NUM_FP_WB_SRC*FP_XLEN-1:0]        src_res;
  logic [NUM_FP_WB_SRC*FP_PREG_WIDTH-1:0]  src_rd;
  logic [NUM_FP_WB_SRC-1:0]                src_we;
  logic [NUM_FP_WB_SRC*FP_FLAG_WIDTH-1:0]  src_exccode;
  logic [NUM_FP_WB_SRC-1:0]                src_valid;
  logic                                    redirect;
  logic [FP_ROB_WIDTH-1:0]                 redirectIdx;
  logic [NUM_FP_WB_PORT-1:0]               wb_en;
  logic [NUM_FP_WB_PORT*FP_ROB_WIDTH-1:0]  wb_robIdx;
  logic [NUM_FP_WB_PORT*FP_XLEN-1:0]       wb_res;
  logic [NUM_FP_WB_PORT*FP_PREG_WIDTH-1:0] wb_rd;
  logic [NUM_FP_WB_PORT-1:0]               wb_we;
  logic [NUM_FP_WB_PORT*FP_FLAG_WIDTH-1:0] wb_exccode;
  logic [NUM_FP_WB_PORT-1:0]               wakeup_en;
  logic [NUM_FP_WB_PORT*FP_PREG_WIDTH-1:0] wakeup_rd;

  modport slave (
    input  src_en, src_robIdx, src_res, src_rd, src_we, src_exccode,
    input  redirect, redirectIdx,
    output src_valid,
    output wb_en, wb_robIdx, wb_res, wb_rd, wb_we, wb_exccode,
    output wakeup_en, wakeup_rd
  );

  modport master (
    output src_en, src_robIdx, src_res, src_rd, src_we, src_exccode,
    output redirect, redirectIdx,
    input  src_valid,
    input  wb_en, wb_robIdx, wb_res, wb_rd, wb_we, wb_exccode,
    input  wakeup_en, wakeup_rd
  );
endinterface

// File: rtl/fp_wb_arbiter_wb_rotate_select.sv
// Picks the first K set bits of req scanning upward from start (wrapping);
// grant k goes to port k in scan order.
module wb_rotate_select #(
  parameter int N  = 4,
  parameter int K  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]        req,
  input  logic [IW-1:0]       start,
  output logic [N-1:0]        grant,
  output logic [K-1:0][N-1:0] sel,
  output logic [K-1:0]        port_vld
);

  logic [IW:0] pos;
  logic        taken;

  // rotated scan, each hit fills the lowest free port
  always_comb begin
    grant    = '0;
    sel      = '0;
    port_vld = '0;
    pos      = '0;
    taken    = 1'b0;
    for (int off = 0; off < N; off++) begin
      pos = {1'b0, start} + (IW+1)'(off);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end else begin
        pos = pos;
      end
      taken = 1'b0;
      for (int k = 0; k < K; k++) begin
        if (req[pos[IW-1:0]] && !taken && !port_vld[k]) begin
          port_vld[k]            = 1'b1;
          sel[k][pos[IW-1:0]]    = 1'b1;
          grant[pos[IW-1:0]]     = 1'b1;
          taken                  = 1'b1;
        end else begin
          taken = taken;
        end
      end
    end
  end

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP writeback arbiter: grants up to NUM_PORT of NUM_SRC slots per cycle and
// registers them onto the writeback/wakeup ports. FP_WB_ARB_RR_EN selects round-robin.
module fp_wb_arbiter
  import fp_wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = NUM_FP_WB_SRC,
  parameter int NUM_PORT   = NUM_FP_WB_PORT,
  parameter int XLEN       = FP_XLEN,
  parameter int ROB_WIDTH  = FP_ROB_WIDTH,
  parameter int PREG_WIDTH = FP_PREG_WIDTH,
  parameter int FLAG_WIDTH = FP_FLAG_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  fp_wb_arbiter_if.slave bus
);

  localparam int SIW = $clog2(NUM_SRC);

  fp_wb_entry_t                     src_s [NUM_SRC];
  fp_wb_entry_t                     nxt_s [NUM_PORT];
  fp_wb_entry_t                     wb_r  [NUM_PORT];
  logic [NUM_SRC-1:0]               kill_s;
  logic [NUM_SRC-1:0]               cand_s;
  logic [NUM_SRC-1:0]               grant_s;
  logic [NUM_PORT-1:0][NUM_SRC-1:0] sel_s;
  logic [NUM_PORT-1:0]              port_vld_s;
  logic [NUM_PORT-1:0]              wb_en_s;
  logic [SIW-1:0]                   start_s;

  // unpack producer slots and squash those younger than a redirect
  always_comb begin
    kill_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_s[i].en      = bus.src_en[i];
      src_s[i].robIdx  = bus.src_robIdx[i*ROB_WIDTH +: ROB_WIDTH];
      src_s[i].res     = bus.src_res[i*XLEN +: XLEN];
      src_s[i].rd      = bus.src_rd[i*PREG_WIDTH +: PREG_WIDTH];
      src_s[i].we      = bus.src_we[i];
      src_s[i].exccode = bus.src_exccode[i*FLAG_WIDTH +: FLAG_WIDTH];
      kill_s[i]        = bus.redirect & loop_compare(src_s[i].robIdx, bus.redirectIdx);
    end
  end

  assign cand_s        = bus.src_en & ~kill_s;
  assign bus.src_valid = grant_s;

`ifdef FP_WB_ARB_RR_EN
  logic [SIW-1:0] rr_ptr_r;
  logic [SIW-1:0] last_s;
  logic [SIW-1:0] rr_nxt_s;

  // slot index of the highest used port is the last one granted in scan order
  always_comb begin
    last_s = '0;
    for (int k = 0; k < NUM_PORT; k++) begin
      if (port_vld_s[k]) begin
        last_s = onehot_to_idx(sel_s[k]);
      end else begin
        last_s = last_s;
      end
    end
    if (last_s == SIW'(NUM_SRC-1)) begin
      rr_nxt_s = '0;
    end else begin
      rr_nxt_s = last_s + SIW'(1);
    end
  end

  // round-robin start pointer, holds when nothing is granted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_r <= '0;
    end else if (|grant_s) begin
      rr_ptr_r <= rr_nxt_s;
    end
  end

  assign start_s = rr_ptr_r;
`else
  assign start_s = '0;
`endif

  wb_rotate_select #(
    .N (NUM_SRC),
    .K (NUM_PORT)
  ) u_sel (
    .req      (cand_s),
    .start    (start_s),
    .grant    (grant_s),
    .sel      (sel_s),
    .port_vld (port_vld_s)
  );

  // route each granted slot onto its port
  always_comb begin
    for (int k = 0; k < NUM_PORT; k++) begin
      nxt_s[k] = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (sel_s[k][i]) begin
          nxt_s[k] = src_s[i];
        end else begin
          nxt_s[k] = nxt_s[k];
        end
      end
      nxt_s[k].en = port_vld_s[k];
    end
  end

  // writeback stage register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_PORT; k++) begin
        wb_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_PORT; k++) begin
        wb_r[k] <= nxt_s[k];
      end
    end
  end

  // a redirect in the writeback cycle still masks younger registered results
  for (genvar k = 0; k < NUM_PORT; k++) begin : g_port
    assign wb_en_s[k]       = wb_r[k].en & ~(bus.redirect & loop_compare(wb_r[k].robIdx, bus.redirectIdx));
    assign bus.wb_en[k]     = wb_en_s[k];
    assign bus.wb_we[k]     = wb_en_s[k] & wb_r[k].we;
    assign bus.wakeup_en[k] = wb_en_s[k] & wb_r[k].we;
    assign bus.wb_robIdx[k*ROB_WIDTH +: ROB_WIDTH]    = wb_r[k].robIdx;
    assign bus.wb_res[k*XLEN +: XLEN]                 = wb_r[k].res;
    assign bus.wb_rd[k*PREG_WIDTH +: PREG_WIDTH]      = wb_r[k].rd;
    assign bus.wakeup_rd[k*PREG_WIDTH +: PREG_WIDTH]  = wb_r[k].rd;
    assign bus.wb_exccode[k*FLAG_WIDTH +: FLAG_WIDTH] = wb_r[k].exccode;
  end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Randomized self-checking bench for fp_wb_arbiter against a queue-style
// reference model; follows FP_WB_ARB_RR_EN when it is defined.
module tb_fp_wb_arbiter;
  import fp_wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_wb_arbiter_if bus();

  fp_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_total = 0;
  int n_bad   = 0;

  // producer slot contents (pending until accepted or squashed)
  logic        p_en  [4];
  logic [5:0]  p_rob [4];
  logic [63:0] p_res [4];
  logic [6:0]  p_rd  [4];
  logic        p_we  [4];
  logic [4:0]  p_exc [4];
  logic        redir;
  logic [5:0]  redir_idx;

  // expected contents of the writeback register stage
  logic        e_en  [2];
  logic [5:0]  e_rob [2];
  logic [63:0] e_res [2];
  logic [6:0]  e_rd  [2];
  logic        e_we  [2];
  logic [4:0]  e_exc [2];
  int          m_rr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // a younger than b when the modular distance a-b lies in the first half of the ROB ring
  function automatic bit younger(input logic [5:0] a, input logic [5:0] b);
    int d;
    d = (int'(a) - int'(b)) & 63;
    return (d >= 1) && (d < 32);
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bus.src_en[i]            = p_en[i];
      bus.src_robIdx[i*6 +: 6] = p_rob[i];
      bus.src_res[i*64 +: 64]  = p_res[i];
      bus.src_rd[i*7 +: 7]     = p_rd[i];
      bus.src_we[i]            = p_we[i];
      bus.src_exccode[i*5 +: 5]= p_exc[i];
    end
    bus.redirect    = redir;
    bus.redirectIdx = redir_idx;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      p_en[i] = 1'b0; p_rob[i] = '0; p_res[i] = '0; p_rd[i] = '0; p_we[i] = 1'b0; p_exc[i] = '0;
    end
    for (int k = 0; k < 2; k++) begin
      e_en[k] = 1'b0; e_rob[k] = '0; e_res[k] = '0; e_rd[k] = '0; e_we[k] = 1'b0; e_exc[k] = '0;
    end
    redir = 1'b0;
    redir_idx = '0;
    m_rr = 0;
  endtask

  task automatic load(input int i, input logic [5:0] rob, input logic [63:0] res,
                      input logic [6:0] rd, input logic we, input logic [4:0] exc);
    p_en[i] = 1'b1; p_rob[i] = rob; p_res[i] = res; p_rd[i] = rd; p_we[i] = we; p_exc[i] = exc;
  endtask

  // one cycle: drive at negedge, check #1 later, then advance the model
  task automatic step();
    logic [3:0] gv;
    int slot [2];
    int cnt;
    int start;
    int idx;
    logic en_x;
    @(negedge clk);
    drive();
    #1;
    gv = '0;
    cnt = 0;
    slot[0] = 0;
    slot[1] = 0;
`ifdef FP_WB_ARB_RR_EN
    start = m_rr;
`else
    start = 0;
`endif
    for (int off = 0; off < 4; off++) begin
      idx = (start + off) % 4;
      if (p_en[idx] && !(redir && younger(p_rob[idx], redir_idx)) && cnt < 2) begin
        gv[idx] = 1'b1;
        slot[cnt] = idx;
        cnt++;
      end
    end
    chk("src_valid", 64'(bus.src_valid), 64'(gv));
    for (int k = 0; k < 2; k++) begin
      en_x = e_en[k] && !(redir && younger(e_rob[k], redir_idx));
      chk($sformatf("wb_en%0d", k), 64'(bus.wb_en[k]), 64'(en_x));
      chk($sformatf("wb_we%0d", k), 64'(bus.wb_we[k]), 64'(en_x & e_we[k]));
      chk($sformatf("wakeup_en%0d", k), 64'(bus.wakeup_en[k]), 64'(en_x & e_we[k]));
      if (e_en[k]) begin
        chk($sformatf("wb_robIdx%0d", k), 64'(bus.wb_robIdx[k*6 +: 6]), 64'(e_rob[k]));
        chk($sformatf("wb_res%0d", k), bus.wb_res[k*64 +: 64], e_res[k]);
        chk($sformatf("wb_rd%0d", k), 64'(bus.wb_rd[k*7 +: 7]), 64'(e_rd[k]));
        chk($sformatf("wakeup_rd%0d", k), 64'(bus.wakeup_rd[k*7 +: 7]), 64'(e_rd[k]));
        chk($sformatf("wb_exc%0d", k), 64'(bus.wb_exccode[k*5 +: 5]), 64'(e_exc[k]));
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (k < cnt) begin
        e_en[k] = 1'b1; e_rob[k] = p_rob[slot[k]]; e_res[k] = p_res[slot[k]];
        e_rd[k] = p_rd[slot[k]]; e_we[k] = p_we[slot[k]]; e_exc[k] = p_exc[slot[k]];
      end else begin
        e_en[k] = 1'b0;
      end
    end
    if (cnt > 0) m_rr = (slot[cnt-1] + 1) % 4;
    for (int i = 0; i < 4; i++) begin
      if (gv[i] || (p_en[i] && redir && younger(p_rob[i], redir_idx))) p_en[i] = 1'b0;
    end
  endtask

  // asynchronous reset asserted between clock edges
  task automatic do_reset();
    rst = 1'b0;
    clear_model();
    drive();
    #1;
    chk("rst_wb_en", 64'(bus.wb_en), 64'd0);
    chk("rst_wakeup_en", 64'(bus.wakeup_en), 64'd0);
    chk("rst_wb_we", 64'(bus.wb_we), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_wb_en", 64'(bus.wb_en), 64'd0);
    chk("rst_hold_wakeup", 64'(bus.wakeup_en), 64'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    clear_model();
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("init_wb_en", 64'(bus.wb_en), 64'd0);
    chk("init_wakeup_en", 64'(bus.wakeup_en), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // single result, one-cycle latency
    load(0, 6'd5, 64'h3F80_0000, 7'd12, 1'b1, 5'h01);
    step();
    chk("t1_src_valid", 64'(bus.src_valid), 64'h1);
    step();
    chk("t1_wb_en", 64'(bus.wb_en), 64'h1);
    chk("t1_wb_rd", 64'(bus.wb_rd[6:0]), 64'd12);
    chk("t1_wb_res", bus.wb_res[63:0], 64'h3F80_0000);
    chk("t1_wakeup_en", 64'(bus.wakeup_en), 64'h1);

    // four pending from a cleared pointer
    step();
    do_reset();
    for (int i = 0; i < 4; i++) load(i, 6'(i + 1), {32'hA5A5_0000, 32'(i)}, 7'(20 + i), 1'b1, 5'(i));
    step();
    chk("t2_grant01", 64'(bus.src_valid), 64'h3);
    step();
    chk("t2_grant23", 64'(bus.src_valid), 64'hC);
    chk("t2_wb01", 64'(bus.wb_en), 64'h3);
    step();
    chk("t2_wb23", 64'(bus.wb_en), 64'h3);
    chk("t2_rd2", 64'(bus.wb_rd[6:0]), 64'd22);
    chk("t2_idle", 64'(bus.src_valid), 64'h0);

    // squash at selection
    do_reset();
    load(0, 6'd8, 64'h1111, 7'd30, 1'b1, 5'd0);
    load(1, 6'd12, 64'h2222, 7'd31, 1'b1, 5'd0);
    redir = 1'b1; redir_idx = 6'd10;
    step();
    chk("t3_src_valid", 64'(bus.src_valid), 64'h1);
    redir = 1'b0;
    step();
    chk("t3_wb_en", 64'(bus.wb_en), 64'h1);
    chk("t3_rob", 64'(bus.wb_robIdx[5:0]), 64'd8);

    // squash in the register stage
    load(0, 6'd12, 64'h3333, 7'd40, 1'b1, 5'd0);
    step();
    redir = 1'b1; redir_idx = 6'd10;
    step();
    chk("t4_wb_en", 64'(bus.wb_en), 64'h0);
    chk("t4_wakeup_en", 64'(bus.wakeup_en), 64'h0);
    redir = 1'b0;

    // reset while both ports are live
    for (int i = 0; i < 4; i++) load(i, 6'(i + 40), 64'(i * 7), 7'(50 + i), 1'b1, 5'd3);
    step();
    step();
    chk("t5_live", 64'(bus.wb_en), 64'h3);
    do_reset();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!p_en[i] && $urandom_range(0, 9) < 6)
          load(i, 6'($urandom), {$urandom, $urandom}, 7'($urandom), 1'($urandom), 5'($urandom));
      end
      redir = ($urandom_range(0, 5) == 0);
      redir_idx = 6'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
